// File: rtl/booth_mul_sched_if.sv
// rtl/booth_mul_sched_if.sv - requester/response bundle of the shared booth64 multiplier scheduler
interface booth_mul_sched_if #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [2*WIDTH-1:0]    resp_z;

    modport master (
        output req_valid, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_z
    );

    modport slave (
        input  req_valid, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_id, resp_z
    );
endinterface

// File: rtl/booth_mul_sched.sv
// rtl/booth_mul_sched.sv - round-robin scheduler sharing one multicycle booth64 multiplier
// Optional feature: BOOTH_SCHED_ZERO_BYPASS_EN (zero operand skips the multiplier).
module booth_mul_sched #(
    parameter int WIDTH   = 64,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_mul_sched_if.slave   bus,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    input  logic [2*WIDTH-1:0] mul_z,
    output logic               busy
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [IDW-1:0]     rr;
    logic [CW-1:0]      cnt;
    logic               launch;
    logic               resp_valid_q;
    logic [IDW-1:0]     resp_id_q;
    logic [2*WIDTH-1:0] resp_z_q;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_idx;
    logic               found;
    int                 p;
    logic [WIDTH-1:0]   sel_x;
    logic [WIDTH-1:0]   sel_y;
    logic               accept;
    logic               bypass;

    // Rotating-priority search starting at the rr pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        p         = 0;
        for (int k = 0; k < NREQ; k++) begin
            p = int'(rr) + k;
            if (p >= NREQ) p = p - NREQ;
            if (!found && bus.req_valid[p]) begin
                found     = 1'b1;
                grant[p]  = 1'b1;
                grant_idx = IDW'(p);
            end
        end
    end

    assign sel_x  = bus.req_x[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_y  = bus.req_y[int'(grant_idx)*WIDTH +: WIDTH];
    assign accept = (state == ST_IDLE) && found;

`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
    assign bypass = (sel_x == '0) || (sel_y == '0);
`else
    assign bypass = 1'b0;
`endif

    // Grants are forced low while rst_n is asserted.
    assign bus.req_ready  = (rst_n && state == ST_IDLE) ? grant : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_z     = resp_z_q;
    assign busy           = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr           <= '0;
            cnt          <= '0;
            launch       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_z_q     <= '0;
            mul_x        <= '0;
            mul_y        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        resp_id_q <= grant_idx;
                        rr        <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
                        if (bypass) begin
                            resp_z_q <= '0;
                            state    <= ST_DONE;
                        end else begin
                            mul_x  <= sel_x;
                            mul_y  <= sel_y;
                            cnt    <= CW'(MUL_LAT - 1);
                            launch <= 1'b1;
                            state  <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    // The first BUSY cycle launches the operands; the counter then spans MUL_LAT settle cycles.
                    if (launch) begin
                        launch <= 1'b0;
                    end else if (cnt == '0) begin
                        resp_z_q     <= mul_z;
                        resp_valid_q <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    // A bypassed transaction enters DONE with resp_valid low and raises it here.
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_sched.sv
// tb/tb_booth_mul_sched.sv - scoreboard bench for booth_mul_sched with a settle-aware multiplier model
module tb_booth_mul_sched;
    localparam int WIDTH   = 64;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int MUL_LAT = 2;

    typedef struct {
        logic [IDW-1:0]     id;
        logic [2*WIDTH-1:0] z;
        int                 lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mul_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();
    logic [WIDTH-1:0]   mul_x;
    logic [WIDTH-1:0]   mul_y;
    logic [2*WIDTH-1:0] mul_z;
    logic               busy;

    booth_mul_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z), .busy(busy)
    );

    // Multiplier model: output is garbage until the operands have been stable long enough.
    logic [WIDTH-1:0]   last_x = '0;
    logic [WIDTH-1:0]   last_y = '0;
    int                 settle = 0;
    logic [2*WIDTH-1:0] prod;
    assign prod  = {{WIDTH{mul_x[WIDTH-1]}}, mul_x} * {{WIDTH{mul_y[WIDTH-1]}}, mul_y};
    assign mul_z = (settle >= MUL_LAT) ? prod : ~prod;
    always @(negedge clk) begin
        if (mul_x !== last_x || mul_y !== last_y) begin
            settle = 0;
            last_x = mul_x;
            last_y = mul_y;
        end else if (settle < 15) begin
            settle = settle + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    int   glog[$];
    int   acc_cyc  = 0;
    int   n_resp   = 0;
    logic rv_prev  = 1'b0;
    logic [IDW-1:0]     last_id = '0;
    logic [2*WIDTH-1:0] last_z  = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        int               g;
        exp_t             e;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        if (!rst_n) begin
            rv_prev = 1'b0;
        end else begin
            if (busy && |bus.req_valid)
                check("ready_while_busy", bus.req_ready, '0);
            if (|(bus.req_valid & bus.req_ready)) begin
                check("grant_onehot", $onehot(bus.req_ready), 1);
                g = 0;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
                x = bus.req_x[g*WIDTH +: WIDTH];
                y = bus.req_y[g*WIDTH +: WIDTH];
                e.id = IDW'(g);
                e.z  = {{WIDTH{x[WIDTH-1]}}, x} * {{WIDTH{y[WIDTH-1]}}, y};
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
                e.lat = (x == '0 || y == '0) ? 1 : MUL_LAT + 1;
`else
                e.lat = MUL_LAT + 1;
`endif
                sb.push_back(e);
                glog.push_back(g);
                acc_cyc = cyc + 1;
            end
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_without_request", sb.size(), 1);
                end else begin
                    if (!rv_prev) check("latency", cyc - acc_cyc, sb[0].lat);
                    check("resp_id", bus.resp_id, sb[0].id);
                    check("resp_z", bus.resp_z, sb[0].z);
                    if (bus.resp_ready) begin
                        e = sb.pop_front();
                        last_id = bus.resp_id;
                        last_z  = bus.resp_z;
                        n_resp++;
                    end
                end
            end
            rv_prev = bus.resp_valid;
        end
    end

    task automatic set_op(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        bus.req_x[i*WIDTH +: WIDTH] = x;
        bus.req_y[i*WIDTH +: WIDTH] = y;
    endtask

    task automatic wait_grants(input int n, input int max_cyc);
        int start;
        start = glog.size();
        for (int c = 0; c < max_cyc && glog.size() < start + n; c++) begin
            @(posedge clk); #1;
        end
        check("grant_count", glog.size(), start + n);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int c = 0; c < max_cyc && (sb.size() != 0 || busy); c++) begin
            @(posedge clk); #1;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        logic [2*WIDTH-1:0] m30000;
        int resp_before;
        m30000 = -128'sd30000;
        bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.resp_ready = 1'b0;

        // Reset held with random inputs
        repeat (4) begin
            @(posedge clk); #1;
            bus.req_valid  = NREQ'($urandom);
            bus.resp_ready = 1'($urandom);
            for (int i = 0; i < NREQ*WIDTH/32; i++) begin
                bus.req_x[i*32 +: 32] = $urandom;
                bus.req_y[i*32 +: 32] = $urandom;
            end
            #1;
            check("rst_req_ready", bus.req_ready, '0);
            check("rst_resp_valid", bus.resp_valid, 0);
            check("rst_resp_id", bus.resp_id, 0);
            check("rst_resp_z", bus.resp_z, 0);
            check("rst_mul_x", mul_x, 0);
            check("rst_mul_y", mul_y, 0);
            check("rst_busy", busy, 0);
        end
        @(posedge clk); #1;
        bus.req_valid = '0; bus.resp_ready = 1'b1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Round robin with all requesters active
        for (int i = 0; i < NREQ; i++)
            set_op(i, 64'(1000 * (i + 1) + 7), -64'(12345 * (i + 3)));
        glog.delete();
        bus.req_valid = '1;
        wait_grants(5, 200);
        bus.req_valid = '0;
        wait_idle(50);
        check("rr_log_size", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            check($sformatf("rr_order%0d", i), glog[i], rr_exp[i]);

        // Single request from req0
        set_op(0, 64'd100, -64'sd300);
        resp_before = n_resp;
        bus.req_valid = 4'b0001;
        wait_grants(1, 50);
        bus.req_valid = '0;
        wait_idle(50);
        check("single_resp", n_resp, resp_before + 1);
        check("single_id", last_id, 0);
        check("single_z", last_z, m30000);

        // Backpressure while others request
        set_op(3, {$urandom, $urandom}, {$urandom, $urandom});
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b1000;
        wait_grants(1, 50);
        bus.req_valid = 4'b0111;
        for (int c = 0; c < 20 && !bus.resp_valid; c++) begin
            @(posedge clk); #1;
        end
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", bus.resp_valid, 1);
            check("bp_req_ready", bus.req_ready, '0);
        end
        bus.req_valid  = '0;
        resp_before    = n_resp;
        bus.resp_ready = 1'b1;
        wait_idle(20);
        check("bp_resp", n_resp, resp_before + 1);
        check("bp_id", last_id, 3);

        // Zero operand
        set_op(1, 64'd0, 64'd12345);
        bus.req_valid = 4'b0010;
        wait_grants(1, 50);
        bus.req_valid = '0;
        wait_idle(50);
        check("zero_id", last_id, 1);
        check("zero_z", last_z, 0);

        // Reset pulse during BUSY
        set_op(2, {$urandom, $urandom | 32'h1}, {$urandom, $urandom | 32'h1});
        bus.req_valid = 4'b0100;
        wait_grants(1, 50);
        bus.req_valid = '0;
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_resp_id", bus.resp_id, 0);
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_mul_x", mul_x, 0);
        check("mid_rst_mul_y", mul_y, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++)
            set_op(i, {$urandom, $urandom}, {$urandom, $urandom});
        glog.delete();
        resp_before   = n_resp;
        bus.req_valid = '1;
        wait_grants(1, 50);
        bus.req_valid = '0;
        wait_idle(50);
        if (glog.size() > 0) check("post_rst_grant", glog[0], 0);
        check("post_rst_resp", n_resp, resp_before + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
